// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit
// Load/store unit between a MIPS pipeline and a word-organised data memory.
// Each request is handled one at a time by a four-state FSM:
//   IDLE  -> accepts a request (req_ready=1 only here)
//   READ  -> one-cycle memory read (loads, and the read half of byte/half stores)
//   WRITE -> one-cycle memory write (word stores, or merged byte/half lane)
//   RESP  -> holds the response until resp_ready
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_store             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed            loads: 1 = sign-extend, 0 = zero-extend
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  extended load data (0 for stores), error flag
//   mem_address           word index {2'b00, addr[31:2]}
//   mem_write_data        word written to memory
//   mem_read_data         combinational read word from memory
//   signal_mem_read/write memory strobes
//
// Build option
//   MIPS_MAU_ALIGN_CHECK_EN : when defined, misaligned halfword/word accesses
//   return resp_err without touching memory; otherwise the offending low
//   address bits are forced to zero.

module mips_mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        signal_mem_read,
   output logic        signal_mem_write
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state, next_state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        store_q;
   logic        signed_q;
   logic        err_q;
   logic [31:0] rword_q;
   logic        req_bad;
   logic        accept;

   // Select the addressed lane and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   res = sgn ? 32'($signed(b)) : {24'h0, b};
         2'b01:   res = sgn ? 32'($signed(h)) : {16'h0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace one byte/half lane of the old word with the new store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
      logic [31:0] res;
      res = word;
      case (size)
         2'b00: begin
            case (off)
               2'd0:    res[7:0]   = data[7:0];
               2'd1:    res[15:8]  = data[7:0];
               2'd2:    res[23:16] = data[7:0];
               default: res[31:24] = data[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) res[31:16] = data[15:0];
            else        res[15:0]  = data[15:0];
         end
         default: res = data;
      endcase
      return res;
   endfunction

   // Force natural alignment; in the checking build misaligned requests
   // never reach memory, so this only matters for the default build.
   function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                              input logic [1:0]  size);
      logic [31:0] res;
      res = addr;
      if (size == 2'b01) res[0]   = 1'b0;
      if (size == 2'b10) res[1:0] = 2'b00;
      return res;
   endfunction

`ifdef MIPS_MAU_ALIGN_CHECK_EN
   assign req_bad = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
   assign req_bad = (req_size == 2'b11);
`endif

   assign accept = (state == IDLE) && req_valid;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Request capture and read-word capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q   <= align_addr(req_addr, req_size);
         wdata_q  <= req_wdata;
         size_q   <= req_size;
         store_q  <= req_store;
         signed_q <= req_signed;
         err_q    <= req_bad;
      end
      if (state == READ) rword_q <= mem_read_data;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_bad)                              next_state = RESP;
               else if (req_store && req_size == 2'b10)  next_state = WRITE;
               else                                      next_state = READ;
            end
         end
         READ:    next_state = store_q ? WRITE : RESP;
         WRITE:   next_state = RESP;
         RESP:    next_state = resp_ready ? IDLE : RESP;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready        = (state == IDLE);
      resp_valid       = (state == RESP);
      resp_err         = (state == RESP) && err_q;
      resp_rdata       = 32'h0;
      mem_address      = 32'h0;
      mem_write_data   = 32'h0;
      signal_mem_read  = (state == READ);
      // Gated by reset so a reset landing on the WRITE cycle commits nothing.
      signal_mem_write = (state == WRITE) && !reset;
      if (state == READ || state == WRITE)
         mem_address = {2'b00, addr_q[31:2]};
      if (state == WRITE)
         mem_write_data = (size_q == 2'b10) ? wdata_q
                                            : store_merge(rword_q, wdata_q, addr_q[1:0], size_q);
      if (state == RESP && !err_q && !store_q)
         resp_rdata = load_extract(rword_q, addr_q[1:0], size_q, signed_q);
   end

endmodule

// File: doc/mips_mem_access_unit.md
MIPS_MEM_ACCESS_UNIT -- requirements
Module: mips_mem_access_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  pipeline load/store request present.
REQ-004 req_ready  output  1  unit can accept a request.
REQ-005 req_store  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned in bits [7:0] / [15:0] / [31:0].
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  consumer accepts the response.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores.
REQ-013 resp_err  output  1  request rejected; no memory access occurred.
REQ-014 mem_address  output  32  word index to data memory, {2'b00, addr[31:2]}.
REQ-015 mem_write_data  output  32  word to data memory.
REQ-016 mem_read_data  input  32  word from data memory (combinational read).
REQ-017 signal_mem_read  output  1  memory read strobe.
REQ-018 signal_mem_write  output  1  memory write strobe; the memory writes on the rising edge while high.

Function
REQ-019 The unit SHALL implement the states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Request capture: in IDLE, req_valid&&req_ready SHALL latch addr, wdata, size, store and signed.
- Next state: READ for loads and for byte/half stores; WRITE for word stores; RESP with resp_err=1 for reserved size.
REQ-021 READ SHALL assert signal_mem_read=1 with mem_address valid for exactly one cycle and capture mem_read_data at the closing edge.
- Load: next state RESP.
- Byte/half store: next state WRITE.
REQ-022 WRITE SHALL assert signal_mem_write=1 for exactly one cycle, then go to RESP.
- mem_write_data = req_wdata for a word store.
- Byte/half store: read word merged with the new byte/half lane.
REQ-023 Byte lanes SHALL be little-endian.
- Byte offset addr[1:0]=n occupies bits [8n+7:8n].
- Halfword at addr[1]=h occupies bits [16h+15:16h].
REQ-024 Load extraction SHALL select the addressed lane, then sign- or zero-extend per req_signed; word loads SHALL ignore req_signed.
REQ-025 RESP SHALL hold resp_valid=1 and stable resp_rdata/resp_err until resp_ready=1, then return to IDLE.
- A new request SHALL NOT be accepted in that same cycle.
REQ-026 Latency from the accept edge T to resp_valid:
- Word load: T+2. Word store: T+2. Byte/half store: T+3. Error: T+1.
REQ-027 Outside READ and WRITE respectively, signal_mem_read and signal_mem_write SHALL be 0; the two SHALL never be 1 together.
REQ-028 Stores SHALL return resp_rdata=0 and resp_err=0.

Reset
REQ-029 While reset=1 at a rising edge, the state SHALL become IDLE and all outputs SHALL be 0 on the following cycle, except req_ready, which SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL drop the in-flight request with no response.
- signal_mem_write SHALL be 0 in any cycle following a reset edge, so no partial read-modify-write is committed.

Configuration
REQ-031 Macro MIPS_MAU_ALIGN_CHECK_EN SHALL control misalignment detection.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL go directly to RESP with resp_err=1 and no memory strobe.
- Undefined: offending low address bits SHALL be treated as 0 (forced alignment), and no error SHALL be raised.
- Reserved size SHALL give an error in both builds.

Verification
REQ-032 Word store then load: sw addr=0x10 data=0xDEADBEEF, then lw 0x10.
- signal_mem_write once with mem_address=4.
- resp_rdata=0xDEADBEEF at T+2.
REQ-033 Byte read-modify-write: mem[4]=0xDEADBEEF, sb addr=0x12 data=0x55.
- One read, then one write of 0xDE55BEEF.
- resp_valid at T+3.
REQ-034 Extension: mem[4]=0xDE55BEEF.
- lb signed 0x13 -> 0xFFFFFFDE.
- lbu 0x13 -> 0x000000DE.
- lh signed 0x12 -> 0xFFFFDE55.
REQ-035 Backpressure: resp_ready=0 for 5 cycles.
- resp_valid and resp_rdata held stable.
- req_ready=0 throughout.
- Accept resumes the cycle after resp_ready=1.
REQ-036 Reset in WRITE cycle of an sb:
- Memory word unchanged.
- No resp_valid.
- req_ready=1 after reset.
REQ-037 Misaligned lw addr=0x11.
- With MIPS_MAU_ALIGN_CHECK_EN: resp_err=1 at T+1, no strobes.
- Without: returns mem[4].
